// File: rtl/timer_pkg.sv
`default_nettype none
//============================================================================
// Module   : timer_pkg
// Brief    : Shared types and constants for the timer block family.
// Revision : 1.0 - initial release
//============================================================================
package timer_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_t;

    localparam logic CAP_EDGE_RISE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/timer_capture_if.sv
`default_nettype none
//============================================================================
// Module   : timer_capture_if
// Brief    : Capture-stream bundle (show-ahead head entry, valid/ready, fill).
// Revision : 1.0 - initial release
//============================================================================
interface timer_capture_if #(
    parameter int BITS  = 4,
    parameter int DEPTH = 4
) ();

    logic [BITS-1:0]          cap_data;
    logic                     cap_edge;
    logic                     cap_valid;
    logic                     cap_ready;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport master (
        output cap_data,
        output cap_edge,
        output cap_valid,
        output fifo_count,
        input  cap_ready
    );

    modport slave (
        input  cap_data,
        input  cap_edge,
        input  cap_valid,
        input  fifo_count,
        output cap_ready
    );

endinterface
`default_nettype wire

// File: rtl/capture_fifo.sv
`default_nettype none
//============================================================================
// Module   : capture_fifo
// Brief    : Synchronous show-ahead FIFO; push while full is accepted only
//            when a pop happens in the same cycle.
// Revision : 1.0 - initial release
//============================================================================
module capture_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_push_data,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);

    localparam int                   c_ADDR_W = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0]    c_FULL_CNT = (c_ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_FULL_CNT);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Head reads as zero when empty so the output is defined out of reset.
    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer_capture.sv
`default_nettype none
//============================================================================
// Module   : timer_capture
// Brief    : Input-capture unit: snapshots timer_value on selected cap_in
//            edges into a FIFO. Optional glitch filter: CAP_FILTER_EN.
// Revision : 1.0 - initial release
//============================================================================
module timer_capture
    import timer_pkg::*;
#(
    parameter int BITS        = 4,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            cap_in,
    input  wire logic [1:0]      edge_sel,
    input  wire logic [BITS-1:0] timer_value,
    timer_capture_if.master      cap_if,
    output logic                 overrun,
    input  wire logic            overrun_clr
);

`ifdef CAP_FILTER_EN
    // The filter delays the level by FILTER_LEN, so arming waits for it too.
    localparam int c_ARM_LEN = SYNC_STAGES + 1 + FILTER_LEN;
`else
    localparam int c_ARM_LEN = SYNC_STAGES + 1;
`endif
    localparam int c_ARM_W = $clog2(SYNC_STAGES + FILTER_LEN + 2);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [c_ARM_W-1:0]     r_arm_cnt;

    logic      w_sync_lvl;
    logic      w_level;
    logic      w_armed;
    logic      w_rise;
    logic      w_fall;
    logic      w_rise_en;
    logic      w_fall_en;
    logic      w_cap_push;
    logic      w_cap_edge;
    logic      w_pop;
    logic      w_full;
    logic      w_empty;
    logic      w_drop;
    edge_sel_t w_sel;

    logic [BITS:0] w_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], cap_in};
        end
    end

    assign w_sync_lvl = r_sync[SYNC_STAGES-1];

`ifdef CAP_FILTER_EN
    localparam int c_FCNT_W = $clog2(FILTER_LEN + 1);

    logic [c_FCNT_W-1:0] r_fcnt;
    logic                r_filt;

    // Any return to the current level restarts the stability count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcnt <= '0;
            r_filt <= 1'b0;
        end else if (w_sync_lvl != r_filt) begin
            if (r_fcnt == c_FCNT_W'(FILTER_LEN - 1)) begin
                r_filt <= w_sync_lvl;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end else begin
            r_fcnt <= '0;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = w_sync_lvl;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= 1'b0;
            r_arm_cnt <= '0;
        end else begin
            r_prev <= w_level;
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + 1'b1;
            end
        end
    end

    assign w_armed   = (r_arm_cnt == c_ARM_W'(c_ARM_LEN));
    assign w_rise    = w_level & ~r_prev;
    assign w_fall    = ~w_level & r_prev;
    assign w_sel     = edge_sel_t'(edge_sel);
    assign w_rise_en = (w_sel == EDGE_RISE) || (w_sel == EDGE_BOTH);
    assign w_fall_en = (w_sel == EDGE_FALL) || (w_sel == EDGE_BOTH);

    assign w_cap_push = w_armed & ((w_rise & w_rise_en) | (w_fall & w_fall_en));
    assign w_cap_edge = w_rise ? CAP_EDGE_RISE : ~CAP_EDGE_RISE;
    assign w_pop      = cap_if.cap_valid & cap_if.cap_ready;

    capture_fifo #(
        .WIDTH (BITS + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_cap_push),
        .i_push_data ({w_cap_edge, timer_value}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (cap_if.fifo_count)
    );

    assign cap_if.cap_data  = w_head[BITS-1:0];
    assign cap_if.cap_edge  = w_head[BITS];
    assign cap_if.cap_valid = ~w_empty;

    // A simultaneous pop frees the slot, so only an unpopped full FIFO drops.
    assign w_drop = w_cap_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (w_drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire
